// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data ports of a hart.
// dmem wins arbitration unless imem has been starved too long; read returns follow an in-order tag FIFO.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_ready,
    input  logic [31:0] i_imem_raddr,
    input  logic        i_imem_ren,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,
    output logic        o_dmem_ready,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [3:0]  i_dmem_mask,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [3:0]  o_mem_mask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic TAG_IMEM = 1'b0;

    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [STV_W-1:0]           starve_q, starve_d;
    logic                       err_q, err_d;

    logic ireq, dreq, d_write, fifo_full, fifo_empty;
    logic gnt_i, gnt_d, rdy_i, rdy_d, push, pop, head_tag;

    // Grant, ready and FIFO push/pop qualification; nothing is granted during reset.
    always_comb begin
        ireq       = i_imem_ren;
        dreq       = i_dmem_ren | i_dmem_wen;
        d_write    = i_dmem_wen;
        fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
        fifo_empty = (cnt_q == '0);
        gnt_d      = !i_rst && dreq && (!ireq || (starve_q != STV_W'(STARVE_LIMIT)));
        gnt_i      = !i_rst && ireq && !gnt_d;
        rdy_d      = gnt_d && i_mem_ready && (d_write || !fifo_full);
        rdy_i      = gnt_i && i_mem_ready && !fifo_full;
        push       = rdy_i || (rdy_d && !d_write);
        pop        = !i_rst && i_mem_valid && !fifo_empty;
        head_tag   = tag_q[rd_ptr_q];
    end

    assign o_imem_ready = rdy_i;
    assign o_dmem_ready = rdy_d;
    assign o_err        = err_q;

    // Request forwarding; a dmem ren+wen collision is forwarded as a write.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_mask  = '0;
        o_mem_wdata = '0;
        if (gnt_d) begin
            o_mem_addr  = i_dmem_addr;
            o_mem_ren   = i_dmem_ren && !d_write && !fifo_full;
            o_mem_wen   = d_write;
            o_mem_mask  = i_dmem_mask;
            o_mem_wdata = i_dmem_wdata;
        end else if (gnt_i) begin
            o_mem_addr  = i_imem_raddr;
            o_mem_ren   = !fifo_full;
            o_mem_mask  = 4'b1111;
        end
    end

    // Same-cycle return routing by the FIFO head tag.
    always_comb begin
        o_imem_valid = pop && (head_tag == TAG_IMEM);
        o_dmem_valid = pop && (head_tag != TAG_IMEM);
        o_imem_rdata = o_imem_valid ? i_mem_rdata : '0;
        o_dmem_rdata = o_dmem_valid ? i_mem_rdata : '0;
    end

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        err_d    = err_q;
        if (push) begin
            tag_d[wr_ptr_q] = rdy_d;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // Starvation counts only dmem wins while imem is actually waiting.
        if (ireq && rdy_d) begin
            if (starve_q != STV_W'(STARVE_LIMIT)) begin
                starve_d = starve_q + STV_W'(1);
            end
        end else if (rdy_i || !ireq) begin
            starve_d = '0;
        end
        if ((i_mem_valid && fifo_empty) || (i_dmem_ren && i_dmem_wen)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the hart's instruction fetch port (imem, read-only) and data port (dmem, read/write).
- Sits between the hart and a single memory instance. Both sides use the same ready/ren/wen/valid protocol the hart uses.
- Tracks outstanding reads in an in-order tag FIFO, so each o_valid/rdata return goes to the requester that issued the read.
- Arbitration: dmem has priority, with an anti-starvation limit for imem.

Parameters:
- MAX_OUTSTANDING, 4: depth of the read-tag FIFO (max in-flight reads); power of two, at least 2.
- STARVE_LIMIT, 3: consecutive dmem wins over a pending imem read before imem is forced to win; at least 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- o_imem_ready  out  1  imem request accepted this cycle if i_imem_ren
- i_imem_raddr  in  32  fetch address
- i_imem_ren  in  1  fetch request
- o_imem_valid  out  1  fetch data valid
- o_imem_rdata  out  32  fetch data
- o_dmem_ready  out  1  dmem request accepted this cycle if ren or wen
- i_dmem_addr  in  32  data address
- i_dmem_ren  in  1  load request
- i_dmem_wen  in  1  store request
- i_dmem_mask  in  4  byte mask
- i_dmem_wdata  in  32  store data
- o_dmem_valid  out  1  load data valid
- o_dmem_rdata  out  32  load data
- i_mem_ready  in  1  memory can accept a request
- o_mem_addr  out  32  forwarded address
- o_mem_ren  out  1  forwarded read
- o_mem_wen  out  1  forwarded write
- o_mem_mask  out  4  forwarded mask
- o_mem_wdata  out  32  forwarded write data
- i_mem_valid  in  1  read data returned (reads only, in order)
- i_mem_rdata  in  32  read data
- o_err  out  1  sticky protocol error

Behaviour:
- Clock i_clk; reset i_rst is synchronous and active-high.
- Reset:
  - Tag FIFO emptied; starve counter = 0; o_err = 0.
  - All ready/valid/ren/wen outputs are 0 during the reset cycle.
  - Reads in flight at reset are discarded; the memory is reset by the same i_rst.
- Request definitions:
  - dreq = i_dmem_ren | i_dmem_wen.
  - ireq = i_imem_ren.
  - i_dmem_ren and i_dmem_wen both high sets o_err; the request is treated as a write.
- Grant (combinational, every cycle):
  - Only ireq: grant imem.
  - Only dreq: grant dmem.
  - Both: grant dmem unless starve_cnt == STARVE_LIMIT, in which case grant imem.
- Forwarding:
  - The granted requester's addr/ren/wen/mask/wdata drive o_mem_*.
  - imem grant drives mask 4'b1111 and wen 0.
  - With no grant, o_mem_ren = o_mem_wen = 0 and the other o_mem_* outputs are 0.
- Read issue gating: a granted read is forwarded (o_mem_ren = 1) only when the FIFO is not full.
  - Full blocks a push even if a pop happens in the same cycle.
  - Writes are never gated by the FIFO.
- Ready:
  - o_X_ready = granted_X & i_mem_ready & (write | !fifo_full).
  - The non-granted side's ready is 0.
  - Acceptance = ready & request in the same cycle; no registering on the request path.
- Tag FIFO:
  - On an accepted read, push tag (0 = imem, 1 = dmem).
  - On i_mem_valid, pop the head and route i_mem_rdata to that owner's o_*_valid/rdata combinationally, in the same cycle.
  - Push and pop in the same cycle are both allowed (when not full before the push).
  - Pointers wrap modulo MAX_OUTSTANDING; the count is tracked separately (0..MAX_OUTSTANDING).
- Unrouted returns: i_mem_valid with an empty FIFO sets o_err and the data is dropped (both valids stay 0). The rdata outputs of a non-valid side are 0.
- Starve counter update per cycle:
  - Increments (saturating at STARVE_LIMIT) when ireq is high and a dmem request is accepted.
  - Clears to 0 when an imem request is accepted or ireq is low.
  - Otherwise holds.
- o_err: sticky until reset.
- Latency: arbiter adds 0 cycles to both the request path and the response path.

Test Plan:
1. imem-only read of addr 0x10 with a memory of latency 4:
   - o_mem_ren = 1 with addr 0x10 in the request cycle.
   - o_imem_valid is high exactly when i_mem_valid is high, with the memory's data.
   - o_dmem_valid stays 0 throughout.
2. imem and dmem reads requested in the same cycle, persistently, with i_mem_ready = 1:
   - dmem is granted 3 times, then imem once, repeating.
   - Returned data is routed in issue order: 3 dmem results, then 1 imem result.
3. dmem write (addr 0x20, mask 4'b0011, wdata 0xDEADBEEF) while the FIFO is full (4 reads outstanding):
   - The write is accepted (o_dmem_ready = 1).
   - A concurrent imem read has o_imem_ready = 0 until a pop.
4. i_mem_ready = 0 for 5 cycles with both sides requesting:
   - Both readies are 0 for those cycles and the FIFO count does not change.
   - Grant resumes on the first cycle ready returns.
5. i_mem_valid pulsed with an empty FIFO:
   - o_err = 1 and stays 1 until i_rst.
   - After reset, o_err = 0 and the FIFO count = 0.
6. i_rst asserted with 2 reads in flight:
   - Next cycle the FIFO is empty.
   - A new imem read of 0x0 issues and returns to imem.
